// File: rtl/log_unit.sv
//-----------------------------------------------------------------------------
// Module   : log_unit
// Function : Iterative integer logarithm for the calculator datapath.
//            Given value and base, finds the largest exponent e with
//            base^e <= value, plus residue = value - base^e and an exact
//            flag. Start/busy/done handshake toward the operation sequencer.
// Options  : LOG_CEIL_EN - when defined, exponent reports the ceiling of the
//            logarithm (residue and exact remain relative to the floor).
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module log_unit #(
  parameter int W_VAL  = 8,
  parameter int W_BASE = 4,
  parameter int W_EXP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [W_VAL-1:0]  value_i,
  input  logic [W_BASE-1:0] base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [W_EXP-1:0]  exponent_o,
  output logic [W_VAL-1:0]  residue_o,
  output logic              exact_o,
  output logic              err_o
);

  // Product width holds acc*base without truncation, so an overflowing
  // candidate power is always seen as larger than value.
  localparam int W_PROD = W_VAL + W_BASE;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [W_VAL-1:0]  value_q,    value_d;
  logic [W_BASE-1:0] base_q,     base_d;
  logic [W_VAL-1:0]  acc_q,      acc_d;
  logic [W_EXP-1:0]  cnt_q,      cnt_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic [W_EXP-1:0]  exponent_q, exponent_d;
  logic [W_VAL-1:0]  residue_q,  residue_d;
  logic              exact_q,    exact_d;
  logic              err_q,      err_d;

  logic [W_PROD-1:0] prod;
  logic              prod_fits;
  logic              operands_bad;
  logic              acc_exact;
  logic [W_EXP-1:0]  exp_result;

  // Candidate next power and its comparison against the captured operand.
  always_comb begin
    prod         = {{W_BASE{1'b0}}, acc_q} * {{W_VAL{1'b0}}, base_q};
    prod_fits    = (prod <= {{W_BASE{1'b0}}, value_q});
    operands_bad = (base_i < W_BASE'(2)) || (value_i == '0);
    acc_exact    = (acc_q == value_q);
  end

  // Exponent reported at completion: floor, or ceiling when the option is built in.
  always_comb begin
`ifdef LOG_CEIL_EN
    exp_result = acc_exact ? cnt_q : (cnt_q + W_EXP'(1));
`else
    exp_result = cnt_q;
`endif
  end

  // Sequencer: operand capture, repeated multiply, result latching.
  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    base_d     = base_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    exponent_d = exponent_q;
    residue_d  = residue_q;
    exact_d    = exact_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          value_d = value_i;
          base_d  = base_i;
          if (operands_bad) begin
            // Illegal operands finish immediately with the value as residue.
            err_d      = 1'b1;
            exponent_d = '0;
            residue_d  = value_i;
            exact_d    = 1'b0;
            state_d    = S_DONE;
          end else begin
            err_d   = 1'b0;
            acc_d   = W_VAL'(1);
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (prod_fits) begin
          // prod <= value, so the low W_VAL bits hold it exactly.
          acc_d = prod[W_VAL-1:0];
          cnt_d = cnt_q + W_EXP'(1);
        end else begin
          exponent_d = exp_result;
          residue_d  = value_q - acc_q;
          exact_d    = acc_exact;
          state_d    = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs are registered straight from the next state.
  always_comb begin
    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      value_q    <= '0;
      base_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      exponent_q <= '0;
      residue_q  <= '0;
      exact_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      base_q     <= base_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      exponent_q <= exponent_d;
      residue_q  <= residue_d;
      exact_q    <= exact_d;
      err_q      <= err_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign exponent_o = exponent_q;
  assign residue_o  = residue_q;
  assign exact_o    = exact_q;
  assign err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_log_unit.sv
//-----------------------------------------------------------------------------
// Module   : tb_log_unit
// Function : Self-checking bench for log_unit: table of directed operations
//            plus hand-written sequences for restart-while-busy and reset
//            abort. Expected exponents follow LOG_CEIL_EN when defined.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_log_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] value;
  logic [3:0] base;
  logic       busy;
  logic       done;
  logic [3:0] exponent;
  logic [7:0] residue;
  logic       exact;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] value;
    logic [3:0] base;
    logic [3:0] e_floor;
    logic [7:0] res;
    logic       ex;
    logic       er;
    int         lat;
  } vec_t;

  vec_t vecs[13];

  log_unit #(.W_VAL(8), .W_BASE(4), .W_EXP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .value_i    (value),
    .base_i     (base),
    .busy_o     (busy),
    .done_o     (done),
    .exponent_o (exponent),
    .residue_o  (residue),
    .exact_o    (exact),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overall time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reported exponent for a given floor result.
  function automatic logic [3:0] exp_model(input logic [3:0] e_floor, input logic ex, input logic er);
    if (er) return 4'd0;
`ifdef LOG_CEIL_EN
    return ex ? e_floor : e_floor + 4'd1;
`else
    return e_floor;
`endif
  endfunction

  // One operation: start at cycle 0, optional re-pulse of start at inj_cyc.
  task automatic run_op(input vec_t v, input int inj_cyc, input string name);
    int  got;
    bit  busy_ok;
    @(negedge clk);
    start = 1'b1;
    value = v.value;
    base  = v.base;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = 8'($urandom);
    base  = 4'($urandom);
    got     = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 20 && got == 0; c++) begin
      @(negedge clk);
      if (c == inj_cyc) begin
        start = 1'b1;
        value = 8'd3;
        base  = 4'd5;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = c;
        if (busy !== 1'b0) busy_ok = 1'b0;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
    start = 1'b0;
    check({name, " latency"},  got, v.lat);
    check({name, " busy"},     {31'd0, busy_ok}, 32'd1);
    check({name, " exponent"}, {28'd0, exponent}, {28'd0, exp_model(v.e_floor, v.ex, v.er)});
    check({name, " residue"},  {24'd0, residue}, {24'd0, v.res});
    check({name, " exact"},    {31'd0, exact}, {31'd0, v.ex});
    check({name, " err"},      {31'd0, err}, {31'd0, v.er});
    @(negedge clk);
    check({name, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    vec_t v;
    //            value  base  floor  res    ex    er    lat
    vecs[0]  = '{8'd8,   4'd2,  4'd3, 8'd0,   1'b1, 1'b0, 5};
    vecs[1]  = '{8'd200, 4'd14, 4'd2, 8'd4,   1'b0, 1'b0, 4};
    vecs[2]  = '{8'd255, 4'd15, 4'd2, 8'd30,  1'b0, 1'b0, 4};
    vecs[3]  = '{8'd225, 4'd15, 4'd2, 8'd0,   1'b1, 1'b0, 4};
    vecs[4]  = '{8'd50,  4'd1,  4'd0, 8'd50,  1'b0, 1'b1, 1};
    vecs[5]  = '{8'd50,  4'd0,  4'd0, 8'd50,  1'b0, 1'b1, 1};
    vecs[6]  = '{8'd0,   4'd3,  4'd0, 8'd0,   1'b0, 1'b1, 1};
    vecs[7]  = '{8'd1,   4'd7,  4'd0, 8'd0,   1'b1, 1'b0, 2};
    vecs[8]  = '{8'd255, 4'd2,  4'd7, 8'd127, 1'b0, 1'b0, 9};
    vecs[9]  = '{8'd100, 4'd10, 4'd2, 8'd0,   1'b1, 1'b0, 4};
    vecs[10] = '{8'd99,  4'd10, 4'd1, 8'd89,  1'b0, 1'b0, 3};
    vecs[11] = '{8'd15,  4'd15, 4'd1, 8'd0,   1'b1, 1'b0, 3};
    vecs[12] = '{8'd14,  4'd15, 4'd0, 8'd13,  1'b0, 1'b0, 2};

    rst_n = 1'b0;
    start = 1'b0;
    value = 8'd0;
    base  = 4'd0;
    repeat (3) @(negedge clk);
    check("reset busy",     {31'd0, busy}, 32'd0);
    check("reset done",     {31'd0, done}, 32'd0);
    check("reset exponent", {28'd0, exponent}, 32'd0);
    check("reset residue",  {24'd0, residue}, 32'd0);
    check("reset exact",    {31'd0, exact}, 32'd0);
    check("reset err",      {31'd0, err}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i], 0, $sformatf("vec%0d", i));
    end

    // Start re-pulsed while busy must be ignored.
    v = '{8'd128, 4'd2, 4'd7, 8'd0, 1'b1, 1'b0, 9};
    run_op(v, 2, "restart_ignored");

    // Reset during CALC aborts with no done.
    @(negedge clk);
    start = 1'b1;
    value = 8'd81;
    base  = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy",     {31'd0, busy}, 32'd0);
    check("abort done",     {31'd0, done}, 32'd0);
    check("abort exponent", {28'd0, exponent}, 32'd0);
    check("abort residue",  {24'd0, residue}, 32'd0);
    check("abort exact",    {31'd0, exact}, 32'd0);
    check("abort err",      {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit saw_done = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (done || busy) saw_done = 1'b1;
      end
      check("abort no_done", {31'd0, saw_done}, 32'd0);
    end

    v = '{8'd81, 4'd3, 4'd4, 8'd0, 1'b1, 1'b0, 6};
    run_op(v, 0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/log_unit.md
Name: log_unit

Overview:
- Iterative integer logarithm; the inverse operation of the calculator's power block.
- Given value and base, computes the largest exponent e with base^e <= value, plus the residue value - base^e and an exact flag.
- Sits in the calculator datapath beside the power unit, driven by the operation sequencer through a start/busy/done handshake.

Parameters:
- W_VAL, 8, width of value and residue (matches power result width)
- W_BASE, 4, width of base (matches power base width)
- W_EXP, 4, width of exponent output

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- value  input  W_VAL  operand to take the logarithm of; captured on the accepted start
- base  input  W_BASE  logarithm base; captured on the accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when results are valid
- exponent  output  W_EXP  floor(log_base(value))
- residue  output  W_VAL  value - base^exponent
- exact  output  1  residue == 0
- err  output  1  illegal operands (base < 2 or value == 0)

Behaviour:
- Reset (async, rst_n low): state=IDLE; busy, done, exact, err = 0; exponent, residue = 0; internal acc = 0.
- States: IDLE, CALC, DONE.
- IDLE: on start=1, capture value/base into internal registers.
  - If base < 2 or value == 0: go to DONE with err=1, exponent=0, residue=value, exact=0.
  - Otherwise: acc=1, cnt=0, go to CALC. err cleared.
- CALC (busy=1):
  - prod = acc*base, computed at W_VAL+W_BASE bits (12 bits), no truncation.
  - If prod <= value: acc=prod, cnt=cnt+1, stay in CALC.
  - Else: exponent=cnt, residue=value-acc[W_VAL-1:0], exact=(acc==value), go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Latency: done is high in cycle exponent+2 after the start edge (the start edge is cycle 0). Error case: done is high in cycle 1.
- exponent, residue, exact and err hold their values until the next accepted start completes.
- start is ignored in CALC and DONE. Captured operands are unaffected by input changes after acceptance.
- Bounds:
  - Maximum exponent is 7 (base 2, value 128..255).
  - value=1 with legal base gives exponent 0, exact=1, residue 0.
- Reset mid-operation aborts immediately to reset values. No done is produced.

Optional Feature:
- Macro LOG_CEIL_EN.
- Defined: exponent reports the ceiling. If exact=0, exponent=cnt+1, otherwise cnt. residue and exact are unchanged (still relative to floor). Latency is unchanged.
- Undefined: exponent is the floor, as above.

Test Plan:
- value=8, base=2, start pulse -> done in cycle 5; exponent=3, residue=0, exact=1, err=0; busy high cycles 1-4.
- value=200, base=14 -> exponent=2, residue=4, exact=0; done in cycle 4. With LOG_CEIL_EN defined: exponent=3.
- value=255, base=15 -> exponent=2 (225), residue=30, exact=0; value=225, base=15 -> exponent=2, exact=1.
- base=1, value=50 -> done in cycle 1, err=1, exponent=0; then base=0 -> err=1; then value=0, base=3 -> err=1.
- value=128, base=2, then start re-pulsed while busy with value=3 -> ignored; result exponent=7, exact=1.
- value=81, base=3, rst_n pulsed low in cycle 2 -> busy=0, done never asserts, all outputs 0. A following start with value=81, base=3 -> exponent=4, exact=1.
